unidade_controle_jogo: RTL and testbench
========================================

# unidade_controle_jogo

Control unit for the sequence-memory game datapath: switch register, 4-bit address counter, 16×4 memory and comparator. A Moore FSM sequences the datapath:
- clears the counter and register on start;
- waits for a switch move, with a bounded timeout;
- registers and compares the move;
- advances the address, or ends the round as win, error or timeout.

It sits between the top level (`iniciar`, result outputs) and the datapath control/status signals.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 3000, number of clock cycles allowed in ESPERA before timing out (3 s at 1 kHz); legal range 2..65535.

Ports:
- `clock`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `iniciar`  in  1  start/restart request, level sampled.
- `tem_jogada`  in  1  high while any switch is set (from the datapath).
- `igual`  in  1  comparator: registered move equals memory data.
- `fimC`  in  1  address counter at last position (15).
- `zeraC`  out  1  synchronous clear of the address counter.
- `contaC`  out  1  increment the address counter.
- `zeraR`  out  1  synchronous clear of the switch register.
- `registraR`  out  1  load the switch register.
- `acertou`  out  1  round won.
- `errou`  out  1  round lost (wrong move or timeout).
- `timeout`  out  1  loss was caused by timeout.
- `pronto`  out  1  round finished.
- `db_estado`  out  4  current state code, for the hex display.

## Operation
- Move detection: internal flop `tj_d` holds the previous `tem_jogada`. `jogada = tem_jogada & ~tj_d`, a one-cycle event per switch press.
- Timeout counter: 16-bit, cleared every cycle the state is not ESPERA, increments in ESPERA.
- States, with their `db_estado` codes:
  - INICIAL 0x0: `iniciar` → PREPARA.
  - PREPARA 0x1: asserts `zeraC` and `zeraR`; → ESPERA.
  - ESPERA 0x2:
    - `jogada` → REGISTRA;
    - otherwise, timeout counter == `TIMEOUT_CYCLES`-1 → FIM_TIMEOUT;
    - otherwise stay.
  - REGISTRA 0x4: asserts `registraR`; → COMPARA.
  - COMPARA 0x5:
    - `!igual` → FIM_ERRO;
    - `igual & fimC` → FIM_ACERTO;
    - otherwise → PROXIMO.
  - PROXIMO 0x6: asserts `contaC`; → ESPERA.
  - FIM_ACERTO 0xA: `acertou`=1, `pronto`=1.
  - FIM_ERRO 0xE: `errou`=1, `pronto`=1.
  - FIM_TIMEOUT 0xD: `errou`=1, `timeout`=1, `pronto`=1.
- Leaving the end states: from any FIM_* state, `iniciar` → PREPARA; otherwise the state holds and its outputs stay held.
- Unused state codes → INICIAL.
- Outputs are a pure decode of the state register (Moore); every output not listed for a state is 0.
- `iniciar` is ignored in states PREPARA through PROXIMO.
- Holding `tem_jogada` high produces exactly one move. A new move requires `tem_jogada` to go low and then high again.
- Simultaneous `jogada` and timeout terminal count in ESPERA: `jogada` wins.

## Timing
- Reset (`reset`=0, asynchronous):
  - state = INICIAL;
  - `tj_d` = 0;
  - timeout counter = 0;
  - all outputs 0, `db_estado` = 0x0.
  - Applies mid-round as well: the round is abandoned immediately, with no clear pulses.
- `iniciar` sampled high at edge k in INICIAL (or a FIM_* state): PREPARA during cycle k..k+1; ESPERA from edge k+1.
- `jogada` sampled at edge k in ESPERA:
  - `registraR` high for cycle k..k+1 (the register loads at edge k+1);
  - COMPARA during k+1..k+2, and `igual`/`fimC` are sampled at edge k+2;
  - the result state (PROXIMO or FIM_*) starts at k+2.
- Correct move: PROXIMO lasts exactly 1 cycle, and the counter increments at edge k+3.
- Timeout: if ESPERA is entered at edge e with no move, FIM_TIMEOUT is entered at edge e+`TIMEOUT_CYCLES`. The counter restarts from 0 on every re-entry to ESPERA.
- `zeraC`, `zeraR`, `registraR` and `contaC` are each single-cycle pulses.

## Test plan
- Reset/idle: `reset`=0 then 1, `iniciar`=0 for 10 cycles → `db_estado`=0x0, all outputs 0. Assert `reset`=0 mid-ESPERA → INICIAL immediately, without waiting for a clock edge.
- Full win: `iniciar` pulse, then 16 correct moves (each `tem_jogada` held 10 cycles, `igual`=1, `fimC`=1 on the 16th) → exactly 16 `registraR` and 15 `contaC` pulses; `acertou`=1, `pronto`=1, `db_estado`=0xA, held until the next `iniciar`.
- Error on 5th move: 4 moves with `igual`=1, 5th with `igual`=0 → 4 `contaC` pulses; FIM_ERRO with `errou`=1, `timeout`=0, `db_estado`=0xE.
- Timeout (`TIMEOUT_CYCLES`=20): `iniciar`, no moves → FIM_TIMEOUT exactly 20 cycles after ESPERA entry; `errou`=1, `timeout`=1, `db_estado`=0xD. Repeat with a correct move at cycle 10 → the count restarts and the timeout fires 20 cycles after re-entry to ESPERA.
- Boundary: `jogada` coincides with terminal count → REGISTRA, not FIM_TIMEOUT. `tem_jogada` held 50 cycles → exactly 1 `registraR`.
- Restart: `iniciar` in FIM_ERRO → PREPARA with `zeraC`=`zeraR`=1 for 1 cycle, then ESPERA. `iniciar` asserted during ESPERA → no effect.

Source files
------------

// File: rtl/unidade_controle_jogo.sv
// Moore control unit for the sequence-memory game: sequences clear/load/compare/advance
// of the datapath and reports win, error or timeout at the end of a round.
module unidade_controle_jogo #(
   parameter int unsigned TIMEOUT_CYCLES = 3000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       tem_jogada,
   input  logic       igual,
   input  logic       fimC,
   output logic       zeraC,
   output logic       contaC,
   output logic       zeraR,
   output logic       registraR,
   output logic       acertou,
   output logic       errou,
   output logic       timeout,
   output logic       pronto,
   output logic [3:0] db_estado
);

   typedef enum logic [3:0] {
      INICIAL     = 4'h0,
      PREPARA     = 4'h1,
      ESPERA      = 4'h2,
      REGISTRA    = 4'h4,
      COMPARA     = 4'h5,
      PROXIMO     = 4'h6,
      FIM_ACERTO  = 4'hA,
      FIM_TIMEOUT = 4'hD,
      FIM_ERRO    = 4'hE
   } t_estado;

   t_estado     r_estado;
   t_estado     w_proximo;
   logic        r_tjD;
   logic [15:0] r_contTimeout;
   logic        w_jogada;
   logic        w_fimTimeout;

   // A move is the rising edge of tem_jogada, so a held switch counts only once
   assign w_jogada     = tem_jogada & ~r_tjD;
   assign w_fimTimeout = (r_contTimeout == 16'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_estado      <= INICIAL;
         r_tjD         <= 1'b0;
         r_contTimeout <= 16'd0;
      end else begin
         r_estado <= w_proximo;
         r_tjD    <= tem_jogada;
         if (r_estado == ESPERA)
            r_contTimeout <= r_contTimeout + 16'd1;
         else
            r_contTimeout <= 16'd0;
      end
   end

   always_comb begin
      w_proximo = r_estado;
      case (r_estado)
         INICIAL:     if (iniciar) w_proximo = PREPARA;
         PREPARA:     w_proximo = ESPERA;
         ESPERA: begin
            if (w_jogada)
               w_proximo = REGISTRA;
            else if (w_fimTimeout)
               w_proximo = FIM_TIMEOUT;
         end
         REGISTRA:    w_proximo = COMPARA;
         COMPARA: begin
            if (!igual)
               w_proximo = FIM_ERRO;
            else if (fimC)
               w_proximo = FIM_ACERTO;
            else
               w_proximo = PROXIMO;
         end
         PROXIMO:     w_proximo = ESPERA;
         FIM_ACERTO,
         FIM_ERRO,
         FIM_TIMEOUT: if (iniciar) w_proximo = PREPARA;
         default:     w_proximo = INICIAL;
      endcase
   end

   always_comb begin
      zeraC     = 1'b0;
      contaC    = 1'b0;
      zeraR     = 1'b0;
      registraR = 1'b0;
      acertou   = 1'b0;
      errou     = 1'b0;
      timeout   = 1'b0;
      pronto    = 1'b0;
      case (r_estado)
         PREPARA: begin
            zeraC = 1'b1;
            zeraR = 1'b1;
         end
         REGISTRA:    registraR = 1'b1;
         PROXIMO:     contaC    = 1'b1;
         FIM_ACERTO: begin
            acertou = 1'b1;
            pronto  = 1'b1;
         end
         FIM_ERRO: begin
            errou  = 1'b1;
            pronto = 1'b1;
         end
         FIM_TIMEOUT: begin
            errou   = 1'b1;
            timeout = 1'b1;
            pronto  = 1'b1;
         end
         default: ;
      endcase
   end

   assign db_estado = r_estado;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Directed bench for unidade_controle_jogo with a short timeout (20 cycles) so every
// round outcome, the move edge detector and the timeout boundary can be exercised.
module tb_unidade_controle_jogo;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       iniciar = 1'b0;
   logic       tem_jogada = 1'b0;
   logic       igual = 1'b0;
   logic       fimC = 1'b0;
   logic       zeraC, contaC, zeraR, registraR;
   logic       acertou, errou, timeout, pronto;
   logic [3:0] db_estado;

   int passed = 0;
   int total  = 0;
   int nRegistra = 0;
   int nConta    = 0;
   int nZeraC    = 0;
   int baseRegistra, baseConta, baseZeraC;

   localparam logic [7:0] OUT_NONE  = 8'b0000_0000;
   localparam logic [7:0] OUT_PREP  = 8'b1010_0000;
   localparam logic [7:0] OUT_REG   = 8'b0001_0000;
   localparam logic [7:0] OUT_CONTA = 8'b0100_0000;
   localparam logic [7:0] OUT_WIN   = 8'b0000_1001;
   localparam logic [7:0] OUT_ERR   = 8'b0000_0101;
   localparam logic [7:0] OUT_TMO   = 8'b0000_0111;

   wire [7:0] outVec = {zeraC, contaC, zeraR, registraR, acertou, errou, timeout, pronto};

   unidade_controle_jogo #(.TIMEOUT_CYCLES(20)) dut (
      .clock      (clock),
      .reset      (reset),
      .iniciar    (iniciar),
      .tem_jogada (tem_jogada),
      .igual      (igual),
      .fimC       (fimC),
      .zeraC      (zeraC),
      .contaC     (contaC),
      .zeraR      (zeraR),
      .registraR  (registraR),
      .acertou    (acertou),
      .errou      (errou),
      .timeout    (timeout),
      .pronto     (pronto),
      .db_estado  (db_estado)
   );

   always #5 clock = ~clock;

   // Pulse counters sample mid-cycle, away from the active edge
   always @(negedge clock) begin
      if (registraR) nRegistra++;
      if (contaC)    nConta++;
      if (zeraC)     nZeraC++;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      total++;
      assert (observed === expected) passed++;
      else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
   endtask

   task automatic checkState(input string tag, input logic [3:0] expState, input logic [7:0] expOut);
      checkOutput({tag, ".estado"}, {12'd0, db_estado}, {12'd0, expState});
      checkOutput({tag, ".saidas"}, {8'd0, outVec}, {8'd0, expOut});
   endtask

   // One move: switch held 10 cycles, then released for 2; returns in ESPERA or an end state
   task automatic applyStimulus(input logic igualVal, input logic fimCVal,
                                input logic [3:0] expResult, input logic [7:0] expResultOut);
      tem_jogada = 1'b1;
      igual      = igualVal;
      fimC       = fimCVal;
      tick(1);
      checkState("move.registra", 4'h4, OUT_REG);
      tick(1);
      checkState("move.compara", 4'h5, OUT_NONE);
      tick(1);
      checkState("move.resultado", expResult, expResultOut);
      tick(7);
      tem_jogada = 1'b0;
      tick(2);
   endtask

   task automatic startRound();
      iniciar = 1'b1;
      tick(1);
      checkState("start.prepara", 4'h1, OUT_PREP);
      iniciar = 1'b0;
      tick(1);
      checkState("start.espera", 4'h2, OUT_NONE);
   endtask

   initial begin
      $display("[TB] start");
      #1;
      checkState("reset.inicio", 4'h0, OUT_NONE);
      tick(3);
      checkState("reset.ativo", 4'h0, OUT_NONE);
      reset = 1'b1;
      tick(10);
      checkState("idle", 4'h0, OUT_NONE);

      // Full win: 15 correct moves then the last with fimC
      baseRegistra = nRegistra;
      baseConta    = nConta;
      startRound();
      for (int i = 0; i < 15; i++)
         applyStimulus(1'b1, 1'b0, 4'h6, OUT_CONTA);
      applyStimulus(1'b1, 1'b1, 4'hA, OUT_WIN);
      checkOutput("win.registraR", 16'(nRegistra - baseRegistra), 16'd16);
      checkOutput("win.contaC", 16'(nConta - baseConta), 16'd15);
      tick(5);
      checkState("win.mantido", 4'hA, OUT_WIN);

      // Restart, iniciar ignored in ESPERA, error on 5th move
      baseRegistra = nRegistra;
      baseConta    = nConta;
      startRound();
      iniciar = 1'b1;
      tick(2);
      checkState("espera.iniciarIgnorado", 4'h2, OUT_NONE);
      iniciar = 1'b0;
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b1, 1'b0, 4'h6, OUT_CONTA);
      applyStimulus(1'b0, 1'b0, 4'hE, OUT_ERR);
      checkOutput("erro.contaC", 16'(nConta - baseConta), 16'd4);
      checkOutput("erro.registraR", 16'(nRegistra - baseRegistra), 16'd5);
      checkState("erro.mantido", 4'hE, OUT_ERR);

      // Restart from FIM_ERRO: one clear pulse, then plain timeout
      baseZeraC = nZeraC;
      startRound();
      checkOutput("restart.zeraC", 16'(nZeraC - baseZeraC), 16'd1);
      tick(19);
      checkState("tmo.antes", 4'h2, OUT_NONE);
      tick(1);
      checkState("tmo.dispara", 4'hD, OUT_TMO);

      // Move at cycle 10 restarts the timeout count
      startRound();
      tick(9);
      tem_jogada = 1'b1;
      igual      = 1'b1;
      fimC       = 1'b0;
      tick(1);
      checkState("tmo2.registra", 4'h4, OUT_REG);
      tem_jogada = 1'b0;
      tick(2);
      checkState("tmo2.proximo", 4'h6, OUT_CONTA);
      tick(1);
      checkState("tmo2.espera", 4'h2, OUT_NONE);
      tick(19);
      checkState("tmo2.antes", 4'h2, OUT_NONE);
      tick(1);
      checkState("tmo2.dispara", 4'hD, OUT_TMO);

      // Move on the terminal-count cycle wins; long hold gives one move
      startRound();
      tick(19);
      baseRegistra = nRegistra;
      tem_jogada = 1'b1;
      tick(1);
      checkState("limite.jogadaVence", 4'h4, OUT_REG);
      tick(49);
      checkOutput("hold50.registraR", 16'(nRegistra - baseRegistra), 16'd1);
      checkState("hold50.timeout", 4'hD, OUT_TMO);
      tem_jogada = 1'b0;

      // Asynchronous reset in the middle of ESPERA
      startRound();
      tick(3);
      #2;
      reset = 1'b0;
      #1;
      checkState("reset.assincrono", 4'h0, OUT_NONE);
      tick(2);
      reset = 1'b1;
      tick(3);
      checkState("reset.aposRound", 4'h0, OUT_NONE);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "[TB] watchdog");
   end

endmodule
